// File: rtl/addsub_cmd_sequencer.sv
// Command FIFO and issue/capture sequencer for the registered add/sub/accumulate unit.
// Issues one command per cycle and returns each adder result three edges after issue.
module addsub_cmd_sequencer #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [N-1:0] CmdA,
    input  logic [N-1:0] CmdB,
    input  logic         CmdSub,
    input  logic         CmdAcc,
    input  logic         IssueEn,
    output logic [N-1:0] OpA,
    output logic [N-1:0] OpB,
    output logic         OpSel,
    output logic         OpAddSub,
    input  logic [N-1:0] AdderZ,
    input  logic         AdderOvf,
    output logic         ResValid,
    output logic [N-1:0] ResData,
    output logic         ResOverflow,
    output logic         StickyOvf,
    input  logic         ClearOvf,
    output logic [2:0]   InFlight
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]     fifo_a [DEPTH];
    logic [N-1:0]     fifo_b [DEPTH];
    logic [DEPTH-1:0] fifo_sub;
    logic [DEPTH-1:0] fifo_acc;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [2:0]       tag;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    // Readiness looks only at the registered fill level, so a full FIFO
    // never accepts, even when the head issues on the same edge.
    assign CmdReady = !full;
    assign push     = CmdValid && !full;
    assign pop      = !empty && IssueEn;

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_a[wr_idx]   <= CmdA;
            fifo_b[wr_idx]   <= CmdB;
            fifo_sub[wr_idx] <= CmdSub;
            fifo_acc[wr_idx] <= CmdAcc;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Idle slots issue Z+0 so the adder's accumulator survives gaps.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            OpA      <= '0;
            OpB      <= '0;
            OpSel    <= 1'b1;
            OpAddSub <= 1'b0;
        end else if (pop) begin
            OpA      <= fifo_a[rd_idx];
            OpB      <= fifo_b[rd_idx];
            OpSel    <= fifo_acc[rd_idx];
            OpAddSub <= fifo_sub[rd_idx];
        end else begin
            OpB      <= '0;
            OpSel    <= 1'b1;
            OpAddSub <= 1'b0;
        end
    end

    // tag[k] marks a command issued k+1 edges ago; tag[2] means Z is valid now.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tag         <= '0;
            ResValid    <= 1'b0;
            ResData     <= '0;
            ResOverflow <= 1'b0;
        end else begin
            tag      <= {tag[1:0], pop};
            ResValid <= tag[2];
            if (tag[2]) begin
                ResData     <= AdderZ;
                ResOverflow <= AdderOvf;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            InFlight <= '0;
        end else begin
            InFlight <= InFlight + {2'b00, pop} - {2'b00, tag[2]};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            StickyOvf <= 1'b0;
        end else if (ResValid && ResOverflow) begin
            StickyOvf <= 1'b1;
        end else if (ClearOvf) begin
            StickyOvf <= 1'b0;
        end
    end

endmodule

// File: doc/addsub_cmd_sequencer.md
Name: addsub_cmd_sequencer

Overview:
- Upstream command stage for the registered n-bit adder/subtractor/accumulator.
- Buffers operation commands in a small FIFO and issues one command per cycle to the adder's A/B/Sel/AddSub inputs.
- Drives a hold-value idle operation when it has nothing to issue.
- Captures the adder's Z/Overflow at the correct pipeline delay and returns each result with a valid pulse, plus a sticky overflow flag.

Parameters:
- N, 16, operand/result width; must match the adder width.
- DEPTH, 4, command FIFO depth; power of 2, at least 2.

Ports:
- Clock  in  1  clock; all registers on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- CmdValid  in  1  command present.
- CmdReady  out  1  FIFO can accept a command; equals !full.
- CmdA  in  N  operand A (ignored when CmdAcc=1).
- CmdB  in  N  operand B.
- CmdSub  in  1  0 = add, 1 = subtract.
- CmdAcc  in  1  1 = use the previous adder result in place of A.
- IssueEn  in  1  1 = head command may issue this cycle.
- OpA  out  N  to adder A.
- OpB  out  N  to adder B.
- OpSel  out  1  to adder Sel.
- OpAddSub  out  1  to adder AddSub.
- AdderZ  in  N  from adder Z.
- AdderOvf  in  1  from adder Overflow.
- ResValid  out  1  one-cycle pulse; result valid.
- ResData  out  N  result value.
- ResOverflow  out  1  overflow flag of this result.
- StickyOvf  out  1  set by any returned overflow.
- ClearOvf  in  1  synchronous clear of StickyOvf.
- InFlight  out  3  number of issued commands whose results have not yet been returned (0..3).

Behaviour:
- Reset values: CmdReady=1, OpA=0, OpB=0, OpSel=1, OpAddSub=0, ResValid=0, ResData=0, ResOverflow=0, StickyOvf=0, InFlight=0. FIFO is emptied.
- Accept: on an edge where CmdValid&&CmdReady, the command {A,B,Sub,Acc} is written at the FIFO tail.
- When full, CmdReady=0 even if a pop occurs the same cycle (no pass-through).
- Issue: on an edge where the FIFO is non-empty and IssueEn=1, the head is popped and loaded into the Op registers: OpA=A, OpB=B, OpSel=Acc, OpAddSub=Sub. A simultaneous push and pop is allowed.
- Idle: on any edge with no issue, the Op registers load OpSel=1, OpAddSub=0, OpB=0; OpA holds. This makes the adder compute Z+0, so the accumulator value is preserved across gaps.
- Issue never passes through: a command accepted at edge a issues at edge a+1 at the earliest.
- Adder timing: the adder registers its inputs one edge after issue and its Z one edge later. Command issued at edge e → adder Z valid after edge e+2.
- Capture: a 3-stage valid shift register tagged at issue. At edge e+3 the block registers ResData=AdderZ and ResOverflow=AdderOvf, and ResValid=1 for exactly one cycle.
- Minimum accept-to-ResValid latency: 4 cycles. Throughput: 1 result/cycle.
- Back-to-back accumulate commands are correct without stalls: the adder's Z feedback already provides forwarding.
- ResData/ResOverflow hold their values when ResValid=0.
- InFlight increments on issue and decrements on ResValid; both in the same cycle leaves it unchanged.
- Sticky flag: StickyOvf sets on an edge with ResValid&&ResOverflow. ClearOvf clears it; if both occur in the same cycle, set wins.
- Arithmetic is the adder's: two's-complement, wrap modulo 2^N. This block does not modify values.
- The first command after reset with CmdAcc=1 accumulates onto 0, because the adder shares Reset.
- Reset mid-operation: FIFO contents, in-flight tags, and pending results are discarded. No ResValid is produced for pre-reset commands.

Test Plan:
- Add: push {A=100,B=23,Sub=0,Acc=0}, IssueEn=1 → ResValid 4 cycles after accept, ResData=123, ResOverflow=0.
- Subtract/overflow: push {5,7,Sub=1} then {0x7FFF,1,Sub=0} back-to-back → results 0xFFFE with ovf=0, then 0x8000 with ovf=1. StickyOvf=1 and stays set; pulse ClearOvf → 0.
- Accumulate across gaps: push load {10,0,add,Acc=0}, then {x,5,add,Acc=1}, {x,5,add,Acc=1}. Wait 3 idle cycles, then push {x,3,Sub=1,Acc=1} → results 10, 15, 20, 17 in order. AdderZ stays 20 during the gap.
- Full/backpressure: IssueEn=0, push 5 commands → 4 accepted, CmdReady=0 on the 5th. Set IssueEn=1 → 4 ResValid pulses on consecutive cycles in FIFO order; InFlight peaks at 3.
- Simultaneous push/pop at full: with FIFO full and IssueEn=1, hold CmdValid → CmdReady=0 that cycle, 1 on the next; no command is lost or duplicated.
- Reset mid-op: with 2 commands in flight and 2 queued, assert Reset for 1 cycle → no further ResValid. InFlight=0, StickyOvf=0, and the next Acc=1 command with B=4 returns 4.
